// File: rtl/qam_symbol_source.sv
// qam_symbol_source: pseudo-random 16-QAM test source for the MER chain.
// Produces Gray-mapped 4-ASK levels on I and Q from a 22-bit LFSR, zero-stuffed
// sample streams at 4x symbol rate, and a frame-aligned clear_accum pulse.
// Optional feature: define SYM_SRC_NOISE_EN to add scaled LFSR noise to samples.
module qam_symbol_source #(
    parameter logic [21:0] SEED       = 22'h000001,
    parameter int          FRAME_LOG2 = 18,
    parameter int          WARMUP     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_clk_en,
    input  logic               smp_clk_en,
    input  logic               enable,
    input  logic [1:0]         noise_sel,
    output logic signed [17:0] sym_i,
    output logic signed [17:0] sym_q,
    output logic [1:0]         sym_bits_i,
    output logic [1:0]         sym_bits_q,
    output logic signed [17:0] sample_i,
    output logic signed [17:0] sample_q,
    output logic               sym_valid,
    output logic               clear_accum,
    output logic [1:0]         state
);

    localparam logic [21:0] SEED_EFF = (SEED == 22'd0) ? 22'd1 : SEED;
    localparam int          WARM_N   = (WARMUP < 1) ? 1 : WARMUP;
    localparam int          WCNT_W   = $clog2(WARM_N + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                 cur_state, nxt_state;
    logic [21:0]            lfsr, lfsr_n, lfsr_step;
    logic [FRAME_LOG2-1:0]  frame_cnt, frame_n;
    logic [WCNT_W-1:0]      wcnt, wcnt_n;
    logic signed [17:0]     lvl_i, lvl_q, smp_new_i, smp_new_q;
    logic signed [17:0]     sym_i_n, sym_q_n, sample_i_n, sample_q_n;
    logic [1:0]             bits_i_n, bits_q_n;
    logic                   sym_valid_n, clear_n, emit;

    function automatic logic signed [17:0] gray_level(input logic [1:0] b);
        case (b)
            2'b00:   gray_level = 18'sh28000;
            2'b01:   gray_level = 18'sh38000;
            2'b11:   gray_level = 18'sh08000;
            default: gray_level = 18'sh18000;
        endcase
    endfunction

    // Next LFSR value (zero state reloads the seed) and the levels it selects
    always_comb begin
        lfsr_step = (lfsr == 22'd0) ? SEED_EFF : {lfsr[20:0], lfsr[21] ^ lfsr[20]};
        lvl_i     = gray_level(lfsr_step[1:0]);
        lvl_q     = gray_level(lfsr_step[3:2]);
    end

`ifdef SYM_SRC_NOISE_EN
    logic [15:0]        nlfsr;
    logic signed [17:0] noise;
    logic signed [18:0] sum_i, sum_q;

    function automatic logic signed [17:0] sat18(input logic signed [18:0] s);
        if (s > 19'sd131071)
            sat18 = 18'sd131071;
        else if (s < -19'sd131071)
            sat18 = -18'sd131071;
        else
            sat18 = s[17:0];
    endfunction

    // Noise generator advances on every sample enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            nlfsr <= 16'hACE1;
        else if (smp_clk_en)
            nlfsr <= {nlfsr[14:0], nlfsr[15] ^ nlfsr[13] ^ nlfsr[12] ^ nlfsr[10]};
    end

    // Scale the noise by noise_sel and add it to the fresh symbol with saturation
    always_comb begin
        noise = $signed({{2{nlfsr[15]}}, nlfsr}) >>> (3'd5 - {1'b0, noise_sel});
        if (noise_sel == 2'd0)
            noise = '0;
        sum_i     = {lvl_i[17], lvl_i} + {noise[17], noise};
        sum_q     = {lvl_q[17], lvl_q} + {noise[17], noise};
        smp_new_i = sat18(sum_i);
        smp_new_q = sat18(sum_q);
    end
`else
    logic unused_noise_sel;
    assign unused_noise_sel = ^noise_sel;

    // Without the noise option the samples carry the clean symbol levels
    always_comb begin
        smp_new_i = lvl_i;
        smp_new_q = lvl_q;
    end
`endif

    // Next-state, LFSR stepping, frame counting and next output values
    always_comb begin
        nxt_state   = cur_state;
        lfsr_n      = lfsr;
        frame_n     = frame_cnt;
        wcnt_n      = wcnt;
        sym_i_n     = sym_i;
        sym_q_n     = sym_q;
        bits_i_n    = sym_bits_i;
        bits_q_n    = sym_bits_q;
        sample_i_n  = sample_i;
        sample_q_n  = sample_q;
        sym_valid_n = 1'b0;
        clear_n     = 1'b0;
        emit        = 1'b0;
        if (!enable) begin
            nxt_state  = ST_IDLE;
            lfsr_n     = SEED_EFF;
            frame_n    = '0;
            wcnt_n     = '0;
            sym_i_n    = '0;
            sym_q_n    = '0;
            bits_i_n   = '0;
            bits_q_n   = '0;
            sample_i_n = '0;
            sample_q_n = '0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    lfsr_n  = SEED_EFF;
                    frame_n = '0;
                    wcnt_n  = '0;
                    if (sym_clk_en) begin
                        emit = 1'b1;
                        if (WARM_N == 1) begin
                            nxt_state = ST_RUN;
                            clear_n   = 1'b1;
                        end else begin
                            nxt_state = ST_WARMUP;
                            wcnt_n    = WCNT_W'(1);
                        end
                    end
                end
                ST_WARMUP: begin
                    if (sym_clk_en) begin
                        emit = 1'b1;
                        if (wcnt == WCNT_W'(WARM_N - 1)) begin
                            nxt_state = ST_RUN;
                            clear_n   = 1'b1;
                            wcnt_n    = '0;
                            frame_n   = '0;
                        end else begin
                            wcnt_n = wcnt + WCNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (sym_clk_en) begin
                        emit        = 1'b1;
                        sym_valid_n = 1'b1;
                        if (frame_cnt == '1) begin
                            clear_n = 1'b1;
                            frame_n = '0;
                        end else begin
                            frame_n = frame_cnt + FRAME_LOG2'(1);
                        end
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
            if (emit) begin
                lfsr_n   = lfsr_step;
                sym_i_n  = lvl_i;
                sym_q_n  = lvl_q;
                bits_i_n = lfsr_step[1:0];
                bits_q_n = lfsr_step[3:2];
            end
            if (smp_clk_en) begin
                sample_i_n = emit ? smp_new_i : 18'sd0;
                sample_q_n = emit ? smp_new_q : 18'sd0;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= ST_IDLE;
            lfsr        <= SEED_EFF;
            frame_cnt   <= '0;
            wcnt        <= '0;
            sym_i       <= '0;
            sym_q       <= '0;
            sym_bits_i  <= '0;
            sym_bits_q  <= '0;
            sample_i    <= '0;
            sample_q    <= '0;
            sym_valid   <= 1'b0;
            clear_accum <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            lfsr        <= lfsr_n;
            frame_cnt   <= frame_n;
            wcnt        <= wcnt_n;
            sym_i       <= sym_i_n;
            sym_q       <= sym_q_n;
            sym_bits_i  <= bits_i_n;
            sym_bits_q  <= bits_q_n;
            sample_i    <= sample_i_n;
            sample_q    <= sample_q_n;
            sym_valid   <= sym_valid_n;
            clear_accum <= clear_n;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_qam_symbol_source.sv
// tb_qam_symbol_source: directed sequence with randomized sample spacing and
// enable drops, compared every clock against a symbol-level reference model.
module tb_qam_symbol_source;

    localparam logic [21:0] SEED       = 22'h000001;
    localparam int          FRAME_LOG2 = 4;
    localparam int          FRAME      = 1 << FRAME_LOG2;
    localparam int          WARM       = 16;

    logic               clk;
    logic               reset;
    logic               sym_clk_en;
    logic               smp_clk_en;
    logic               enable;
    logic [1:0]         noise_sel;
    logic signed [17:0] sym_i, sym_q, sample_i, sample_q;
    logic [1:0]         sym_bits_i, sym_bits_q, state;
    logic               sym_valid, clear_accum;

    int checks     = 0;
    int errors     = 0;
    int clear_seen = 0;
    int valid_seen = 0;

    logic [21:0]        m_lfsr;
    int                 m_nsym;
    int                 m_state;
    logic               m_valid, m_clear;
    logic signed [17:0] exp_i, exp_q, exp_si, exp_sq;
    logic [1:0]         exp_bi, exp_bq;
    logic signed [17:0] zs [4];
    int                 zs_n;

    qam_symbol_source #(
        .SEED(SEED),
        .FRAME_LOG2(FRAME_LOG2),
        .WARMUP(WARM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sym_clk_en(sym_clk_en),
        .smp_clk_en(smp_clk_en),
        .enable(enable),
        .noise_sel(noise_sel),
        .sym_i(sym_i),
        .sym_q(sym_q),
        .sym_bits_i(sym_bits_i),
        .sym_bits_q(sym_bits_q),
        .sample_i(sample_i),
        .sample_q(sample_q),
        .sym_valid(sym_valid),
        .clear_accum(clear_accum),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray index 00,01,11,10 -> 0..3, level = (2*idx-3)/4 full scale
    function automatic logic signed [17:0] level_of(input logic [1:0] b);
        int idx;
        idx = 2 * int'(b[1]) + int'(b[1] ^ b[0]);
        return 18'((2 * idx - 3) * 32768);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = SEED;
        m_nsym  = 0;
        m_state = 0;
        m_valid = 1'b0;
        m_clear = 1'b0;
        exp_i   = '0;
        exp_q   = '0;
        exp_si  = '0;
        exp_sq  = '0;
        exp_bi  = '0;
        exp_bq  = '0;
    endtask

    // Symbol-level model: symbols counted from start, frames by modulo
    task automatic model_step(input logic sym, input logic smp, input logic en);
        logic [21:0] fb;
        m_valid = 1'b0;
        m_clear = 1'b0;
        if (!en) begin
            model_reset();
        end else if (sym) begin
            fb      = ((m_lfsr >> 21) ^ (m_lfsr >> 20)) & 22'd1;
            m_lfsr  = (m_lfsr << 1) | fb;
            m_nsym  = m_nsym + 1;
            exp_bi  = 2'(m_lfsr % 4);
            exp_bq  = 2'((m_lfsr / 4) % 4);
            exp_i   = level_of(exp_bi);
            exp_q   = level_of(exp_bq);
            if (m_nsym < WARM) begin
                m_state = 1;
            end else begin
                m_state = 2;
                if (m_nsym == WARM) begin
                    m_clear = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    if (((m_nsym - WARM) % FRAME) == 0)
                        m_clear = 1'b1;
                end
            end
            if (smp) begin
                exp_si = exp_i;
                exp_sq = exp_q;
            end
        end else if (smp) begin
            exp_si = '0;
            exp_sq = '0;
        end
    endtask

    task automatic check_output();
        check_val("state",       32'(state),       32'(m_state));
        check_val("sym_i",       32'(sym_i),       32'(exp_i));
        check_val("sym_q",       32'(sym_q),       32'(exp_q));
        check_val("sym_bits_i",  32'(sym_bits_i),  32'(exp_bi));
        check_val("sym_bits_q",  32'(sym_bits_q),  32'(exp_bq));
        check_val("sample_i",    32'(sample_i),    32'(exp_si));
        check_val("sample_q",    32'(sample_q),    32'(exp_sq));
        check_val("sym_valid",   32'(sym_valid),   32'(m_valid));
        check_val("clear_accum", 32'(clear_accum), 32'(m_clear));
    endtask

    task automatic apply_stimulus(input logic sym, input logic smp, input logic en);
        @(negedge clk);
        sym_clk_en = sym;
        smp_clk_en = smp;
        enable     = en;
        noise_sel  = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        model_step(sym, smp, en);
        check_output();
        if (clear_accum === 1'b1) clear_seen++;
        if (sym_valid === 1'b1) valid_seen++;
        if (smp && zs_n < 4) begin
            zs[zs_n] = sample_i;
            zs_n++;
        end
    endtask

    // One symbol period: four sample enables, the first carrying the symbol enable
    task automatic run_symbol(input logic en, input int gap_max);
        zs_n = 0;
        for (int s = 0; s < 4; s++) begin
            apply_stimulus(s == 0, 1'b1, en);
            repeat ($urandom_range(0, gap_max)) apply_stimulus(1'b0, 1'b0, en);
        end
    endtask

    task automatic check_symbol_one(input string tag);
        check_val({tag, "_i"},      32'(sym_i),      32'(18'sh18000));
        check_val({tag, "_q"},      32'(sym_q),      32'(18'sh28000));
        check_val({tag, "_bits_i"}, 32'(sym_bits_i), 32'(2'b10));
        check_val({tag, "_bits_q"}, 32'(sym_bits_q), 32'(2'b00));
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        sym_clk_en = 1'b0;
        smp_clk_en = 1'b0;
        noise_sel  = 2'd0;
        zs_n       = 0;
        model_reset();
        @(negedge clk);
        $display("[TB] reset state");
        check_output();
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] 100 symbol enables with enable low");
        for (int n = 0; n < 100; n++) run_symbol(1'b0, 1);
        check_val("idle_clears", 32'(clear_seen), 32'd0);

        $display("[TB] start-up and warmup");
        clear_seen = 0;
        valid_seen = 0;
        run_symbol(1'b1, 0);
        check_symbol_one("sym1");
        check_val("sym1_state", 32'(state), 32'd1);
        run_symbol(1'b1, 1);
        check_val("sym2_i", 32'(sym_i), 32'(18'sh28000));
        check_val("sym2_q", 32'(sym_q), 32'(18'sh38000));
        for (int n = 3; n < WARM; n++) run_symbol(1'b1, 1);
        check_val("warm_state",  32'(state),      32'd1);
        check_val("warm_clears", 32'(clear_seen), 32'd0);
        check_val("warm_valids", 32'(valid_seen), 32'd0);
        run_symbol(1'b1, 1);
        check_val("run_state",        32'(state),      32'd2);
        check_val("transition_clear", 32'(clear_seen), 32'd1);

        $display("[TB] three frames");
        for (int n = 0; n < 3 * FRAME; n++) run_symbol(1'b1, 2);
        check_val("frame_clears", 32'(clear_seen), 32'd4);
        check_val("frame_valids", 32'(valid_seen), 32'(3 * FRAME));
        check_val("stuff0", 32'(zs[0]), 32'(exp_i));
        check_val("stuff1", 32'(zs[1]), 32'd0);
        check_val("stuff2", 32'(zs[2]), 32'd0);
        check_val("stuff3", 32'(zs[3]), 32'd0);

        $display("[TB] abort at run symbol 7");
        for (int n = 0; n < 7; n++) run_symbol(1'b1, 0);
        clear_seen = 0;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_val("abort_state", 32'(state),      32'd0);
        check_val("abort_sym_i", 32'(sym_i),      32'd0);
        check_val("abort_smp_i", 32'(sample_i),   32'd0);
        check_val("abort_clear", 32'(clear_seen), 32'd0);
        run_symbol(1'b1, 0);
        check_symbol_one("restart");

        $display("[TB] asynchronous reset mid-run");
        for (int n = 0; n < 20; n++) run_symbol(1'b1, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("areset_state", 32'(state),    32'd0);
        check_val("areset_sym_i", 32'(sym_i),    32'd0);
        check_val("areset_smp_q", 32'(sample_q), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_symbol(1'b1, 0);
        check_symbol_one("post_reset");

        $display("[TB] randomized spacing and enable drops");
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0)
                repeat ($urandom_range(1, 3)) run_symbol(1'b0, 1);
            else
                run_symbol(1'b1, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam_symbol_source.md
# qam_symbol_source

Transmit-side test source for the MER measurement chain. Generates pseudo-random 16-QAM symbols, with 4-ASK levels on I and Q, from an LFSR. Drives zero-stuffed sample streams toward the pulse-shaping filter and raises a frame-aligned `clear_accum` pulse so the receive-side error and power accumulators integrate over exact symbol frames. It sits between the clock-phase generator and the I/Q transmit filters, as the counterpart of the slicer/MER receiver.

## Interface
Parameters:
- `SEED`, 22'h000001: LFSR reload value. A value of 0 is replaced by 1.
- `FRAME_LOG2`, 18: frame length is 2^FRAME_LOG2 symbols.
- `WARMUP`, 16: symbols discarded after start, to flush the downstream pipeline.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `sym_clk_en`, input, 1: symbol-rate enable, one `clk` wide.
- `smp_clk_en`, input, 1: sample-rate enable, 4× symbol rate. Coincides with `sym_clk_en`.
- `enable`, input, 1: level run request.
- `noise_sel`, input, 2: impairment level. Used only when `SYM_SRC_NOISE_EN` is defined.
- `sym_i`, `sym_q`, output, 18 signed 1s17: current symbol value.
- `sym_bits_i`, `sym_bits_q`, output, 2: current Gray bits.
- `sample_i`, `sample_q`, output, 18 signed 1s17: zero-stuffed sample stream.
- `sym_valid`, output, 1: one-cycle pulse when a new symbol is registered in RUN.
- `clear_accum`, output, 1: one-cycle frame-boundary pulse.
- `state`, output, 2: FSM state.

## Operation
- The FSM has three states: IDLE=0, WARMUP=1 and RUN=2.
  - IDLE to WARMUP: on the first `sym_clk_en` with `enable`=1.
  - WARMUP to RUN: after `WARMUP` symbol enables.
  - Any state to IDLE: on the next `clk` edge after `enable`=0.
- In IDLE:
  - the LFSR is held at `SEED`;
  - the symbol counter is held at 0;
  - all data outputs are 0.
- LFSR: 22-bit Fibonacci, x^22+x^21+1.
  - fb = lfsr[21]^lfsr[20]; the next value is {lfsr[20:0], fb}.
  - It steps once per `sym_clk_en` in WARMUP and RUN.
  - An all-zero state is reloaded with `SEED`.
- Bit selection: I bits = next_lfsr[1:0]; Q bits = next_lfsr[3:2].
- Gray mapping:
  - 00 → -0.75 (18'sh28000)
  - 01 → -0.25 (18'sh38000)
  - 11 → +0.25 (18'sh08000)
  - 10 → +0.75 (18'sh18000)
- Samples:
  - On `smp_clk_en` with `sym_clk_en`=1, `sample_x` takes the new symbol value.
  - On `smp_clk_en` alone, `sample_x` takes 0.
  - Otherwise `sample_x` holds.
- In WARMUP, symbols and samples are driven but `sym_valid`=0 and `clear_accum`=0.
- Symbol counter: `FRAME_LOG2` bits wide, counting RUN symbols.
  - `clear_accum` asserts on the RUN symbol edge where the counter equals 2^FRAME_LOG2−1; the counter then wraps to 0.
  - `clear_accum` also asserts on the WARMUP→RUN transition edge, which starts the first frame.

## Timing
- Reset values: all outputs are 0, `state`=IDLE, LFSR=`SEED`, counter=0.
- All outputs are registered. A symbol enable sampled at edge N shows its new value after edge N, one-cycle latency.
- `sym_valid` and `clear_accum` are exactly one `clk` wide and coincide with the `sym_i` update.
- `enable` falling mid-frame: IDLE is entered and outputs are zeroed on the next edge. No `clear_accum` is issued.
- `enable` rising again restarts WARMUP from `SEED`, so the sequence is deterministic.
- `reset` mid-operation clears asynchronously, regardless of the enables.
- `smp_clk_en` without `sym_clk_en` never steps the LFSR. `sym_clk_en` without `smp_clk_en` is illegal; the samples then hold.

## Configuration
- `SYM_SRC_NOISE_EN` defined:
  - A second 16-bit LFSR, x^16+x^14+x^13+x^11+1 with seed 16'hACE1, steps on every `smp_clk_en`.
  - Its value, sign-extended to 18 bits and arithmetically right-shifted by (5 − `noise_sel`), is added to the non-zero samples.
  - `noise_sel`=0 adds nothing.
  - The sum saturates to ±(2^17−1).
  - `sym_i` and `sym_q` stay clean.
- `SYM_SRC_NOISE_EN` undefined: no noise logic is built, `noise_sel` is ignored, and the samples are the clean symbol values.

## Test plan
- Reset with `SEED`=1: all outputs are 0 and `state`=0. They remain so while `enable`=0 across 100 symbol enables.
- Start up with `WARMUP`=16 and `enable`=1:
  - symbol 1 gives LFSR 0x000002, I bits=10 (+0.75, 18'sh18000) and Q bits=00 (18'sh28000);
  - symbol 2 gives I=00 (18'sh28000) and Q=01 (18'sh38000);
  - `state`=2 after the 16th enable;
  - a single `clear_accum` pulse occurs at the transition.
- Frame wrap with `FRAME_LOG2`=4: `clear_accum` pulses every 16 RUN symbols, each coincident with `sym_valid`; there are 0 pulses during WARMUP.
- Zero stuffing: across 4 consecutive `smp_clk_en` pulses, `sample_i` equals the symbol value on the first and 0 on the next three.
- Abort: drop `enable` at RUN symbol 7. On the next edge `state`=0, the outputs are 0 and there is no `clear_accum`. Re-enabling reproduces the symbol 1 values above.
- Noise (macro defined):
  - `noise_sel`=0 gives samples identical to the clean run.
  - `noise_sel`=3 gives non-zero sample deviation bounded by |2^15>>2|.
  - No output exceeds ±131071.
